// File: rtl/fifo_read_serializer.sv
// -----------------------------------------------------------------------------
// fifo_read_serializer
//
// Pops PAR_READ words at a time from a wide FIFO read window into a holding
// register, then presents them one per cycle on a valid/ready stream,
// oldest word first. When the last held word is accepted and another window
// is available, the next window is popped in the same edge, so a full FIFO
// drains at one word per cycle with no bubble.
//
// Optional feature: define SER_LAST_EN to add packet framing (a packet
// counter and the out_last port marking every PACKET_LEN-th word).
//
// Ports:
//   clk              in   single clock, rising edge
//   rst              in   synchronous active-high reset
//   fifo_data        in   FIFO read window, element 0 is the oldest word
//   fifo_empty       in   FIFO holds fewer than PAR_READ words
//   fifo_read_enable out  pop strobe, FIFO advances by PAR_READ words
//   out_data         out  serial output word
//   out_valid        out  out_data is valid
//   out_ready        in   consumer accepts when out_valid & out_ready
//   busy             out  holding register has unsent words
//   out_last         out  (SER_LAST_EN only) final word of a packet
// -----------------------------------------------------------------------------
module fifo_read_serializer #(
  parameter int DATA_WIDTH = 8,
  parameter int PAR_READ   = 4,
  parameter int PACKET_LEN = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] fifo_data [0:PAR_READ-1],
  input  logic                  fifo_empty,
  output logic                  fifo_read_enable,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy
`ifdef SER_LAST_EN
  ,
  output logic                  out_last
`endif
);

  // Index counter is at least one bit wide so PAR_READ=1 still elaborates.
  localparam int              IDX_W    = (PAR_READ > 1) ? $clog2(PAR_READ) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAR_READ - 1);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [DATA_WIDTH-1:0]   hold_q [0:PAR_READ-1];

  logic at_last_s;
  logic valid_s;
  logic accept_s;
  logic pop_s;

  // Decode whether the current word is the final one of the held window.
  always_comb begin
    at_last_s = 1'b0;
    if (PAR_READ == 1) begin
      // A single-word window: every acceptance empties the holding register.
      at_last_s = 1'b1;
    end else begin
      at_last_s = (idx_q == IDX_LAST);
    end
  end

  // Handshake and pop qualification; reset masks everything so a reset
  // mid-stream never pops the FIFO and never shows a valid word.
  always_comb begin
    valid_s  = (state_q == ST_STREAM) && !rst;
    accept_s = valid_s && out_ready;
    pop_s    = !rst && !fifo_empty &&
               ((state_q == ST_IDLE) || (accept_s && at_last_s));
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (pop_s) begin
          state_d = ST_STREAM;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_STREAM: begin
        if (accept_s && at_last_s) begin
          // Reload in the same edge when another window is ready.
          state_d = pop_s ? ST_STREAM : ST_IDLE;
        end else begin
          state_d = ST_STREAM;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM outputs; out_data is forced to zero only while reset is held.
  always_comb begin
    fifo_read_enable = pop_s;
    out_valid        = valid_s;
    busy             = valid_s;
    if (rst) begin
      out_data = '0;
    end else begin
      out_data = hold_q[idx_q];
    end
  end

  // Next index: restart on a pop, step on each accepted non-final word.
  always_comb begin
    idx_d = idx_q;
    if (pop_s) begin
      idx_d = '0;
    end else if (accept_s && !at_last_s) begin
      idx_d = idx_q + IDX_W'(1);
    end else begin
      idx_d = idx_q;
    end
  end

  // Holding register and index; a pop captures the whole read window.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q <= '0;
      for (int i = 0; i < PAR_READ; i++) begin
        hold_q[i] <= '0;
      end
    end else begin
      idx_q <= idx_d;
      if (pop_s) begin
        for (int i = 0; i < PAR_READ; i++) begin
          hold_q[i] <= fifo_data[i];
        end
      end
    end
  end

`ifdef SER_LAST_EN
  localparam int              CNT_W    = (PACKET_LEN > 1) ? $clog2(PACKET_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PACKET_LEN - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Packet counter steps on every accepted word and wraps at the packet end.
  always_comb begin
    cnt_d = cnt_q;
    if (accept_s) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Packet counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Last-word marker follows the valid word currently on the output.
  always_comb begin
    out_last = valid_s && (cnt_q == CNT_LAST);
  end
`else
  // Framing is compiled out; PACKET_LEN is kept only for a uniform interface.
  logic unused_packet_len_s;
  assign unused_packet_len_s = (PACKET_LEN > 0);
`endif

endmodule

// File: tb/tb_fifo_read_serializer.sv
// -----------------------------------------------------------------------------
// tb_fifo_read_serializer
//
// Bench for fifo_read_serializer (DATA_WIDTH=8, PAR_READ=4). A small FIFO
// model feeds the read window; every word loaded into the model is also
// pushed to an expected-word queue and popped when the serializer hands it
// over. Define SER_LAST_EN to include the packet framing scenario.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fifo_read_serializer;

  logic       clk;
  logic       rst;
  logic [7:0] fifo_data [0:3];
  logic       fifo_empty;
  logic       fifo_read_enable;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
`ifdef SER_LAST_EN
  logic       out_last;
`endif

  logic [7:0] mdl_q [$];
  logic [7:0] exp_q [$];
  int         checks;
  int         failures;
  int         pop_cnt;

`ifdef SER_LAST_EN
  fifo_read_serializer #(.DATA_WIDTH(8), .PAR_READ(4), .PACKET_LEN(6)) dut (
    .clk(clk), .rst(rst), .fifo_data(fifo_data), .fifo_empty(fifo_empty),
    .fifo_read_enable(fifo_read_enable), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
    .out_last(out_last)
  );
`else
  fifo_read_serializer #(.DATA_WIDTH(8), .PAR_READ(4)) dut (
    .clk(clk), .rst(rst), .fifo_data(fifo_data), .fifo_empty(fifo_empty),
    .fifo_read_enable(fifo_read_enable), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present the head of the FIFO model on the read window.
  task automatic drive_fifo();
    fifo_empty = (mdl_q.size() < 4);
    for (int i = 0; i < 4; i++) begin
      fifo_data[i] = (i < mdl_q.size()) ? mdl_q[i] : 8'h00;
    end
  endtask

  task automatic load_word(input logic [7:0] w);
    mdl_q.push_back(w);
    exp_q.push_back(w);
  endtask

  // One clock: sample the pop strobe mid-cycle, advance the model on the edge.
  task automatic tick();
    logic       pop_seen;
    logic [7:0] tmp;
    @(negedge clk);
    pop_seen = fifo_read_enable;
    @(posedge clk);
    if (pop_seen) begin
      pop_cnt++;
      for (int i = 0; i < 4; i++) begin
        if (mdl_q.size() > 0) tmp = mdl_q.pop_front();
      end
    end
    #1;
    drive_fifo();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    out_ready = 1'b1;
    tick();
    tick();
    load_word(8'h5A); load_word(8'h5B); load_word(8'h5C); load_word(8'h5D);
    drive_fifo();
    #1;
    checks++; if (fifo_read_enable !== 1'b0) begin failures++; $display("FAIL reset_pop: got %b expected 0", fifo_read_enable); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (out_data !== 8'h00) begin failures++; $display("FAIL reset_data: got %h expected 00", out_data); end
    tick();
    checks++; if (mdl_q.size() != 4) begin failures++; $display("FAIL reset_nopop: fifo words %0d expected 4", mdl_q.size()); end
    mdl_q.delete();
    exp_q.delete();
    drive_fifo();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_single_pop();
    logic [7:0] exp;
    int         pops0;
    out_ready = 1'b1;
    load_word(8'h11); load_word(8'h22); load_word(8'h33); load_word(8'h44);
    drive_fifo();
    #1;
    checks++; if (fifo_read_enable !== 1'b1) begin failures++; $display("FAIL single_pop_en: got %b expected 1", fifo_read_enable); end
    pops0 = pop_cnt;
    tick();
    for (int k = 0; k < 4; k++) begin
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL single_valid[%0d]: got %b expected 1", k, out_valid); end
      exp = exp_q.pop_front();
      checks++; if (out_data !== exp) begin failures++; $display("FAIL single_data[%0d]: got %h expected %h", k, out_data, exp); end
      checks++; if (fifo_read_enable !== 1'b0) begin failures++; $display("FAIL single_nopop[%0d]: got %b expected 0", k, fifo_read_enable); end
      tick();
    end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL single_done_valid: got %b expected 0", out_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_done_busy: got %b expected 0", busy); end
    checks++; if (pop_cnt - pops0 != 1) begin failures++; $display("FAIL single_pop_count: got %0d expected 1", pop_cnt - pops0); end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp;
    out_ready = 1'b1;
    load_word(8'h11); load_word(8'h22); load_word(8'h33); load_word(8'h44);
    drive_fifo();
    #1;
    tick();
    exp = exp_q.pop_front();
    checks++; if (out_data !== exp) begin failures++; $display("FAIL bp_first: got %h expected %h", out_data, exp); end
    tick();
    out_ready = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_hold_valid[%0d]: got %b expected 1", k, out_valid); end
      checks++; if (out_data !== exp_q[0]) begin failures++; $display("FAIL bp_hold_data[%0d]: got %h expected %h", k, out_data, exp_q[0]); end
      checks++; if (fifo_read_enable !== 1'b0) begin failures++; $display("FAIL bp_nopop[%0d]: got %b expected 0", k, fifo_read_enable); end
      tick();
    end
    out_ready = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      exp = exp_q.pop_front();
      checks++; if (out_valid !== 1'b1 || out_data !== exp) begin failures++; $display("FAIL bp_resume[%0d]: got %b/%h expected 1/%h", k, out_valid, out_data, exp); end
      tick();
    end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_done_valid: got %b expected 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp;
    logic       exp_pop;
    int         pops0;
    out_ready = 1'b1;
    for (int w = 1; w <= 8; w++) load_word(8'(w));
    drive_fifo();
    #1;
    pops0 = pop_cnt;
    tick();
    for (int k = 0; k < 8; k++) begin
      exp = exp_q.pop_front();
      exp_pop = (k == 3);
      checks++; if (out_valid !== 1'b1 || out_data !== exp) begin failures++; $display("FAIL b2b_word[%0d]: got %b/%h expected 1/%h", k, out_valid, out_data, exp); end
      checks++; if (fifo_read_enable !== exp_pop) begin failures++; $display("FAIL b2b_pop[%0d]: got %b expected %b", k, fifo_read_enable, exp_pop); end
      tick();
    end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_done_valid: got %b expected 0", out_valid); end
    checks++; if (pop_cnt - pops0 != 2) begin failures++; $display("FAIL b2b_pop_count: got %0d expected 2", pop_cnt - pops0); end
  endtask

  task automatic test_empty();
    out_ready = 1'b1;
    // Three words: fewer than a window, so the FIFO still reports empty.
    mdl_q.push_back(8'hE1); mdl_q.push_back(8'hE2); mdl_q.push_back(8'hE3);
    drive_fifo();
    #1;
    for (int k = 0; k < 6; k++) begin
      checks++; if (fifo_read_enable !== 1'b0) begin failures++; $display("FAIL empty_pop[%0d]: got %b expected 0", k, fifo_read_enable); end
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL empty_valid[%0d]: got %b expected 0", k, out_valid); end
      tick();
    end
    mdl_q.delete();
    drive_fifo();
    #1;
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp;
    int         pops0;
    out_ready = 1'b1;
    for (int w = 0; w < 8; w++) load_word(8'hA1 + 8'(w));
    drive_fifo();
    #1;
    tick();
    for (int k = 0; k < 2; k++) begin
      exp = exp_q.pop_front();
      checks++; if (out_data !== exp) begin failures++; $display("FAIL rmid_pre[%0d]: got %h expected %h", k, out_data, exp); end
      tick();
    end
    rst = 1'b1;
    #1;
    pops0 = pop_cnt;
    checks++; if (fifo_read_enable !== 1'b0) begin failures++; $display("FAIL rmid_pop_in_rst: got %b expected 0", fifo_read_enable); end
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rmid_valid: got %b expected 0", out_valid); end
    checks++; if (out_data !== 8'h00) begin failures++; $display("FAIL rmid_data: got %h expected 00", out_data); end
    checks++; if (pop_cnt != pops0 || mdl_q.size() != 4) begin failures++; $display("FAIL rmid_nopop: pops %0d words %0d expected 0/4", pop_cnt - pops0, mdl_q.size()); end
    // Held words A3/A4 are discarded by the reset.
    exp = exp_q.pop_front();
    exp = exp_q.pop_front();
    rst = 1'b0;
    #1;
    checks++; if (fifo_read_enable !== 1'b1) begin failures++; $display("FAIL rmid_repop: got %b expected 1", fifo_read_enable); end
    tick();
    for (int k = 0; k < 4; k++) begin
      exp = exp_q.pop_front();
      checks++; if (out_valid !== 1'b1 || out_data !== exp) begin failures++; $display("FAIL rmid_post[%0d]: got %b/%h expected 1/%h", k, out_valid, out_data, exp); end
      tick();
    end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rmid_done_valid: got %b expected 0", out_valid); end
  endtask

`ifdef SER_LAST_EN
  task automatic test_framing();
    logic [7:0] exp;
    logic       exp_last;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    for (int w = 0; w < 12; w++) load_word(8'hC0 + 8'(w));
    drive_fifo();
    #1;
    tick();
    for (int k = 1; k <= 12; k++) begin
      exp = exp_q.pop_front();
      exp_last = (k == 6) || (k == 12);
      checks++; if (out_valid !== 1'b1 || out_data !== exp) begin failures++; $display("FAIL frame_word[%0d]: got %b/%h expected 1/%h", k, out_valid, out_data, exp); end
      checks++; if (out_last !== exp_last) begin failures++; $display("FAIL frame_last[%0d]: got %b expected %b", k, out_last, exp_last); end
      tick();
    end
    checks++; if (out_last !== 1'b0) begin failures++; $display("FAIL frame_idle_last: got %b expected 0", out_last); end
  endtask
`endif

  initial begin
    checks    = 0;
    failures  = 0;
    pop_cnt   = 0;
    rst       = 1'b1;
    out_ready = 1'b0;
    drive_fifo();
    test_reset();
    test_single_pop();
    test_backpressure();
    test_back_to_back();
    test_empty();
    test_reset_mid();
`ifdef SER_LAST_EN
    test_framing();
`endif
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL scoreboard_drain: got %0d words left expected 0", exp_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
